// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared state encoding, default polynomial constants and the
//               tap-feedback helper for the BIST pattern generator / MISR.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } state_t;

    // x^5 + x^3 + 1 (maximal length, period 31) and a nonzero start value
    localparam logic [4:0] c_default_taps = 5'b10100;
    localparam logic [4:0] c_default_seed = 5'b00001;

    // Parity of the tapped bits; callers zero-extend narrower registers
    function automatic logic lfsr_feedback(input logic [31:0] state,
                                           input logic [31:0] taps);
        return ^(state & taps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_step_reg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_step_reg
// Description : WIDTH-bit Fibonacci shift register with synchronous load,
//               step enable and a parallel XOR input. With xor_in tied to 0
//               it is a plain LFSR; fed with CUT responses it is a MISR.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_step_reg
    import lfsr_pkg::*;
#(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] TAPS    = c_default_taps,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] xor_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic             w_fb;

    assign w_fb = lfsr_feedback(32'(r_q), 32'(TAPS));
    assign q    = r_q;

    // Load wins over stepping; when neither is asserted the value is frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (load) begin
            r_q <= load_val;
        end else if (en) begin
            r_q <= {r_q[WIDTH-2:0], w_fb} ^ xor_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_bist_ctrl
// Description : BIST sequencer: applies NUM_PAT LFSR patterns to the CUT,
//               compacts the responses in a MISR and compares the final
//               signature with GOLDEN. Supports hold (CUT stall) and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_bist_ctrl
    import lfsr_pkg::*;
#(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] TAPS    = c_default_taps,
    parameter logic [WIDTH-1:0] SEED    = c_default_seed,
    parameter int               NUM_PAT = 31,
    parameter logic [WIDTH-1:0] GOLDEN  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           hold,
    input  logic [WIDTH-1:0]               resp_in,
    output logic [WIDTH-1:0]               pat_out,
    output logic                           pat_valid,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [WIDTH-1:0]               signature,
    output logic [$clog2(NUM_PAT+1)-1:0]   pat_count
);

    localparam int                c_cnt_w = $clog2(NUM_PAT + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_PAT - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_step;
    logic               w_check;
    logic               w_abort;
    logic [WIDTH-1:0]   w_misr;
    logic [c_cnt_w-1:0] r_pat_count;
    logic               r_done;
    logic               r_pass;
    logic [WIDTH-1:0]   r_signature;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes; abort outranks hold and the RUN->CHECK exit
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_check      = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_next = RUN;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end else if (!hold) begin
                    w_step = 1'b1;
                    if (r_pat_count == c_last) begin
                        w_state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                w_state_next = IDLE;
                if (abort) begin
                    w_abort = 1'b1;
                end else begin
                    w_check = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pattern counter: cleared at start, advances with every absorbed pattern
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat_count <= '0;
        end else if (w_load) begin
            r_pat_count <= '0;
        end else if (w_step) begin
            r_pat_count <= r_pat_count + 1'b1;
        end
    end

    // Result registers: done pulses for one cycle after a non-aborted CHECK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_signature <= '0;
        end else begin
            r_done <= w_check;
            if (w_load || w_abort) begin
                r_pass <= 1'b0;
            end else if (w_check) begin
                r_pass <= (w_misr == GOLDEN);
            end
            if (w_check) begin
                r_signature <= w_misr;
            end
        end
    end

    lfsr_step_reg #(
        .WIDTH   (WIDTH),
        .TAPS    (TAPS),
        .RST_VAL (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (SEED),
        .en       (w_step),
        .xor_in   ({WIDTH{1'b0}}),
        .q        (pat_out)
    );

    lfsr_step_reg #(
        .WIDTH   (WIDTH),
        .TAPS    (TAPS),
        .RST_VAL ({WIDTH{1'b0}})
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val ({WIDTH{1'b0}}),
        .en       (w_step),
        .xor_in   (resp_in),
        .q        (w_misr)
    );

    assign pat_valid = (r_state == RUN) && !hold;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = r_signature;
    assign pat_count = r_pat_count;

endmodule
`default_nettype wire

// File: doc/lfsr_bist_ctrl.md
Name: lfsr_bist_ctrl

Overview:
- Built-in self-test sequencer for the ATPG path.
- Owns an internal LFSR pattern generator and drives its pseudo-random patterns onto a circuit-under-test (CUT) for a programmed number of cycles.
- Compacts the CUT responses in a multiple-input signature register (MISR), then compares the final signature against a golden value and reports pass/fail.
- Sits between the top-level test control and the CUT. Replaces a free-running LFSR with a start/run/check sequence.

Parameters:
- WIDTH, 5: pattern, response and signature width in bits.
- TAPS, 5'b10100: feedback tap mask shared by the LFSR and the MISR (x^5+x^3+1; maximal, period 31).
- SEED, 5'b00001: LFSR load value at start; must be nonzero.
- NUM_PAT, 31: patterns per run; legal range 1..2^WIDTH-1.
- GOLDEN, 5'b00000: expected final MISR signature.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: begin a run; honoured only in IDLE.
- abort, input, 1: cancel a run in progress.
- hold, input, 1: stall the run (CUT not ready).
- resp_in, input, WIDTH: CUT response to the pattern currently on pat_out, valid in the same cycle.
- pat_out, output, WIDTH: current LFSR pattern.
- pat_valid, output, 1: pat_out is being applied this cycle.
- busy, output, 1: high in RUN and CHECK.
- done, output, 1: one-cycle pulse when a run completes.
- pass, output, 1: result of the last completed run.
- signature, output, WIDTH: final MISR value of the last run.
- pat_count, output, $clog2(NUM_PAT+1): number of patterns applied so far in the current run.

Behaviour:
- Reset (async, any state): state=IDLE; lfsr=SEED; misr=0; pat_count=0; pat_valid=0; busy=0; done=0; pass=0; signature=0.
- LFSR step: lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- MISR step: misr_next = {misr[WIDTH-2:0], ^(misr & TAPS)} ^ resp_in.
- IDLE:
  - pat_valid=0, busy=0.
  - start=1 → RUN next cycle, with lfsr=SEED, misr=0, pat_count=0, pass=0.
- RUN, hold=0:
  - pat_valid=1, pat_out=lfsr.
  - At the clock edge: MISR absorbs resp_in, LFSR steps, pat_count increments.
  - When pat_count==NUM_PAT-1 at that edge, the last pattern is absorbed and the next state is CHECK.
- RUN, hold=1:
  - pat_valid=0; lfsr, misr and pat_count are frozen.
  - resp_in is ignored.
- CHECK (one cycle):
  - signature<=misr; pass<=(misr==GOLDEN); done=1 in the following cycle.
  - → IDLE.
- Latency: start-to-done = NUM_PAT + (number of hold cycles) + 2 cycles.
- abort=1 in RUN or CHECK:
  - → IDLE next cycle; done is not pulsed.
  - pass=0; signature is unchanged from the previous completed run.
  - abort has priority over hold and over RUN→CHECK.
- start while busy: ignored.
- start and abort together in IDLE: abort wins and the controller stays in IDLE.
- LFSR wrap: after 2^WIDTH-1 steps it returns to SEED. It must never reach the all-zero state.
- pat_out holds its last value when not in RUN; consumers must gate on pat_valid.
- done and pass change only at CHECK completion, abort, or reset.

Decomposition:
- Shared package (lfsr_pkg):
  - state encoding enum: IDLE, RUN, CHECK.
  - default TAPS and SEED constants.
  - a feedback function taking a state and a tap mask.
- One natural sub-module, lfsr_step_reg: a WIDTH-bit shift register with load, enable and optional parallel XOR input. Instantiated twice: once as the LFSR (XOR input tied 0), once as the MISR (XOR input = resp_in).
- The FSM and counter stay in lfsr_bist_ctrl.

Test Plan:
- Reset, then start with resp_in=0 and hold=0:
  - pat_out over the first 6 valid cycles = 00001, 00010, 00100, 01001, 10010, 00101.
  - Exactly 31 valid cycles.
  - done pulses once, 33 cycles after start.
  - signature=00000, pass=1.
- Full 31-pattern run: all 31 pat_out values are distinct and nonzero; the internal lfsr equals 00001 again after the final step.
- resp_in = pat_out loopback: signature matches the bench reference model. With GOLDEN set to that value pass=1; with GOLDEN set to any other value pass=0.
- hold asserted for 3 cycles mid-run:
  - pat_valid=0 during the hold and the pattern sequence resumes unchanged.
  - done arrives 3 cycles later than in the first scenario, with an identical signature.
- abort at pat_count=10:
  - IDLE next cycle, busy=0, no done pulse, pass=0.
  - A subsequent start restarts from 00001.
- rst asserted asynchronously mid-RUN, between clock edges:
  - All outputs go immediately to their reset values.
  - start pulsed while busy has no effect on the sequence or the count.
